hbm_channel_responder: RTL and testbench

HBM_CHANNEL_RESPONDER -- requirements
Module: hbm_channel_responder

---
 rtl/hbm_channel_responder_pkg.sv | 30 +++
 rtl/hbm_rqst_fifo.sv | 57 +++++
 rtl/hbm_channel_responder.sv | 110 +++++++++++
 tb/tb_hbm_channel_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hbm_channel_responder_pkg.sv
// Shared types and helpers for the HBM channel responder.
// The width and latency defaults below are the shared accelerator defaults.
// An integration that predefines these macros overrides them.
`ifndef HBM_AWIDTH
`define HBM_AWIDTH 32
`endif
`ifndef HBM_DWIDTH
`define HBM_DWIDTH 32
`endif
`ifndef MEM_LATENCY
`define MEM_LATENCY 2
`endif
`ifndef PSEUDO_CHANNEL_NUM
`define PSEUDO_CHANNEL_NUM 2
`endif

package hbm_channel_responder_pkg;

  // One entry per issued read; it travels alongside the memory latency.
  typedef struct packed {
    logic vld;
    logic oor;
  } tag_t;

  // An address is out of range when it is at or beyond the populated word count.
  function automatic logic addr_oor(input logic [63:0] addr, input logic [63:0] words);
    return addr >= words;
  endfunction

endpackage

// File: rtl/hbm_rqst_fifo.sv
// Request FIFO holding read addresses until they can be issued to memory.
// The caller gates writes with full_o and reads with empty_o.
module hbm_rqst_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_data_i,
  input  logic             rd_en_i,
  output logic [AW-1:0]    rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [AW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointers and occupancy; simultaneous write and read leave count as is.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(wr_en_i) - CNT_W'(rd_en_i);
  end

  // Control state is cleared on reset; stored addresses are left as they are.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Address storage.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/hbm_channel_responder.sv
// HBM channel responder: queues edge read requests, issues them to a fixed
// latency backing memory and returns the data in request order.
module hbm_channel_responder
  import hbm_channel_responder_pkg::*;
#(
  parameter int          HBM_AWIDTH  = `HBM_AWIDTH,
  parameter int          HBM_DWIDTH  = `HBM_DWIDTH,
  parameter int          RQST_DEPTH  = 8,
  parameter int          FULL_THRESH = 6,
  parameter int          MEM_LATENCY = `MEM_LATENCY,
  parameter int unsigned MEM_WORDS   = 1 << 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HBM_AWIDTH-1:0] rd_hbm_edge_addr,
  input  logic                  rd_hbm_edge_valid,
  output logic                  hbm_controller_full,
  output logic [HBM_DWIDTH-1:0] hbm_controller_edge,
  output logic                  hbm_controller_valid,
  output logic                  mem_rd_en,
  output logic [HBM_AWIDTH-1:0] mem_rd_addr,
  input  logic [HBM_DWIDTH-1:0] mem_rd_data,
  input  logic                  mem_stall,
  output logic                  overflow_err
);

  localparam int CNT_W = $clog2(RQST_DEPTH) + 1;

  logic [CNT_W-1:0]      count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [HBM_AWIDTH-1:0] head_addr;
  logic                  wr_en;
  logic                  issue;

  // Requests arriving at a full FIFO are dropped and flagged.
  assign wr_en = rd_hbm_edge_valid && !fifo_full;
  assign issue = !fifo_empty && !mem_stall;

  hbm_rqst_fifo #(
    .DEPTH (RQST_DEPTH),
    .AW    (HBM_AWIDTH)
  ) u_rqst_fifo (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (rd_hbm_edge_addr),
    .rd_en_i   (issue),
    .rd_data_o (head_addr),
    .count_o   (count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Out-of-range addresses are still read; their data is replaced by zero later.
  assign mem_rd_en   = issue;
  assign mem_rd_addr = issue ? head_addr : '0;

  tag_t tag_in;
  tag_t tag_out;
  tag_t tag_q [MEM_LATENCY];

  assign tag_in  = '{vld: issue, oor: issue && addr_oor(64'(head_addr), 64'(MEM_WORDS))};
  assign tag_out = tag_q[MEM_LATENCY-1];

  // Tag shift register mirrors the memory latency so each tag exits with its data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < MEM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  logic                  valid_q, valid_d;
  logic [HBM_DWIDTH-1:0] edge_q, edge_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;

  // Response capture, registered backpressure and sticky overflow.
  always_comb begin
    valid_d = tag_out.vld;
    edge_d  = edge_q;
    if (tag_out.vld) edge_d = tag_out.oor ? '0 : mem_rd_data;
    full_d  = (count >= CNT_W'(FULL_THRESH));
    ovf_d   = ovf_q | (rd_hbm_edge_valid & fifo_full);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      edge_q  <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      edge_q  <= edge_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign hbm_controller_valid = valid_q;
  assign hbm_controller_edge  = edge_q;
  assign hbm_controller_full  = full_q;
  assign overflow_err         = ovf_q;

endmodule

// File: tb/tb_hbm_channel_responder.sv
// Bench for hbm_channel_responder: an array of pseudo-channels, each with its
// own fixed-latency memory model, all driven by the same request stream.
module tb_hbm_channel_responder;

  localparam int AW        = `HBM_AWIDTH;
  localparam int DW        = `HBM_DWIDTH;
  localparam int L         = `MEM_LATENCY;
  localparam int NCH       = `PSEUDO_CHANNEL_NUM;
  localparam int DEPTH     = 8;
  localparam int THRESH    = 6;
  localparam int MEM_WORDS = 1 << 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          stall;

  logic [NCH-1:0]         ch_full;
  logic [NCH-1:0][DW-1:0] ch_edge;
  logic [NCH-1:0]         ch_valid;
  logic [NCH-1:0]         ch_en;
  logic [NCH-1:0][AW-1:0] ch_addr;
  logic [NCH-1:0][DW-1:0] ch_rdata;
  logic [NCH-1:0]         ch_ovf;

  // Memory contents: address 0x10 holds 0xABCD, everything else a hash.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == AW'(16)) return DW'(32'hABCD);
    return DW'(a * 32'h9E37_79B1 + 32'h1357_2468);
  endfunction

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [AW-1:0] pa [L];
    logic          pv [L];
    always @(posedge clk) begin
      pa[0] <= ch_addr[g];
      pv[0] <= ch_en[g];
      for (int i = 1; i < L; i++) begin
        pa[i] <= pa[i-1];
        pv[i] <= pv[i-1];
      end
    end
    assign ch_rdata[g] = pv[L-1] ? mem_word(pa[L-1]) : DW'(32'hDEAD_BEEF);

    hbm_channel_responder #(
      .RQST_DEPTH  (DEPTH),
      .FULL_THRESH (THRESH),
      .MEM_LATENCY (L),
      .MEM_WORDS   (MEM_WORDS)
    ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .rd_hbm_edge_addr     (rd_addr),
      .rd_hbm_edge_valid    (rd_valid),
      .hbm_controller_full  (ch_full[g]),
      .hbm_controller_edge  (ch_edge[g]),
      .hbm_controller_valid (ch_valid[g]),
      .mem_rd_en            (ch_en[g]),
      .mem_rd_addr          (ch_addr[g]),
      .mem_rd_data          (ch_rdata[g]),
      .mem_stall            (stall),
      .overflow_err         (ch_ovf[g])
    );
  end

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  logic [AW-1:0] fifo_m [$];
  exp_t          exp_m [$];
  logic          m_full;
  logic          m_ovf;
  logic [DW-1:0] m_edge;
  int            cyc;
  int            n_cmp;
  int            n_err;
  int            nvld;
  int            last_vld_cyc;
  logic          full_seen;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: a queue of pending addresses and a queue of scheduled responses.
  task automatic model_step();
    logic          issue;
    logic          exp_v;
    logic          accept;
    logic [DW-1:0] exp_d;
    logic [AW-1:0] exp_a;
    logic [AW-1:0] a;
    exp_t          e;
    issue = (fifo_m.size() > 0) && !stall;
    exp_a = '0;
    if (issue) exp_a = fifo_m[0];
    exp_v = 1'b0;
    exp_d = m_edge;
    if (exp_m.size() > 0 && exp_m[0].due == cyc) begin
      exp_v = 1'b1;
      exp_d = exp_m[0].data;
    end
    for (int c = 0; c < NCH; c++) begin
      check_val("mem_rd_en", 64'(ch_en[c]), 64'(issue));
      check_val("mem_rd_addr", 64'(ch_addr[c]), 64'(exp_a));
      check_val("full", 64'(ch_full[c]), 64'(m_full));
      check_val("overflow_err", 64'(ch_ovf[c]), 64'(m_ovf));
      check_val("valid", 64'(ch_valid[c]), 64'(exp_v));
      check_val("edge", 64'(ch_edge[c]), 64'(exp_d));
    end
    if (ch_valid[0]) begin
      nvld++;
      last_vld_cyc = cyc;
    end
    if (ch_full[0]) full_seen = 1'b1;
    if (exp_v) begin
      m_edge = exp_d;
      void'(exp_m.pop_front());
    end
    m_full = (fifo_m.size() >= THRESH);
    accept = rd_valid && (fifo_m.size() < DEPTH);
    if (rd_valid && fifo_m.size() == DEPTH) m_ovf = 1'b1;
    if (issue) begin
      a = fifo_m.pop_front();
      e.due  = cyc + L + 1;
      e.data = (a >= AW'(MEM_WORDS)) ? '0 : mem_word(a);
      exp_m.push_back(e);
    end
    if (accept) fifo_m.push_back(rd_addr);
    cyc++;
  endtask

  task automatic cycle(input logic v, input logic [AW-1:0] a, input logic s);
    rd_valid = v;
    rd_addr  = a;
    stall    = s;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    for (int c = 0; c < NCH; c++) begin
      check_val({tag, "_full"}, 64'(ch_full[c]), 64'd0);
      check_val({tag, "_valid"}, 64'(ch_valid[c]), 64'd0);
      check_val({tag, "_edge"}, 64'(ch_edge[c]), 64'd0);
      check_val({tag, "_rd_en"}, 64'(ch_en[c]), 64'd0);
      check_val({tag, "_rd_addr"}, 64'(ch_addr[c]), 64'd0);
      check_val({tag, "_ovf"}, 64'(ch_ovf[c]), 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n0;
    int n_sent;
    logic v;
    logic s;
    logic [AW-1:0] a;
    n_cmp = 0; n_err = 0; nvld = 0; last_vld_cyc = -1; full_seen = 1'b0;
    m_full = 1'b0; m_ovf = 1'b0; m_edge = '0; cyc = 0;
    rd_valid = 1'b0; rd_addr = '0; stall = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Single request at 0x10.
    t0 = cyc; n0 = nvld;
    cycle(1'b1, AW'(16), 1'b0);
    idle(L + 4);
    check_val("single_latency", 64'(last_vld_cyc), 64'(t0 + 2 + L));
    check_val("single_count", 64'(nvld - n0), 64'd1);
    check_val("single_edge", 64'(ch_edge[0]), 64'hABCD);

    // Eight back-to-back requests.
    t0 = cyc; n0 = nvld; full_seen = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1'b1, AW'(i), 1'b0);
    idle(L + 3);
    check_val("b2b_count", 64'(nvld - n0), 64'd8);
    check_val("b2b_last", 64'(last_vld_cyc), 64'(t0 + 7 + 2 + L));
    check_val("b2b_no_full", 64'(full_seen), 64'd0);

    // Stalled memory: sender honours full, then ignores it.
    n_sent = 0;
    for (int i = 0; i < 10; i++) begin
      if (!ch_full[0]) begin
        cycle(1'b1, AW'(100 + n_sent), 1'b1);
        n_sent++;
      end else begin
        cycle(1'b0, '0, 1'b1);
      end
    end
    check_val("stall_sent", 64'(n_sent), 64'(THRESH + 1));
    check_val("stall_ovf_clear", 64'(ch_ovf[0]), 64'd0);
    cycle(1'b1, AW'(107), 1'b1);
    check_val("ovf_after_8th", 64'(ch_ovf[0]), 64'd0);
    cycle(1'b1, AW'(108), 1'b1);
    check_val("ovf_after_9th", 64'(ch_ovf[0]), 64'd1);
    cycle(1'b1, AW'(109), 1'b1);
    n0 = nvld;
    idle(DEPTH + L + 3);
    check_val("stall_drain_count", 64'(nvld - n0), 64'd8);

    // Out-of-range address between two in-range neighbours.
    n0 = nvld;
    cycle(1'b1, AW'(5), 1'b0);
    cycle(1'b1, AW'(MEM_WORDS), 1'b0);
    cycle(1'b1, AW'(6), 1'b0);
    idle(L + 4);
    check_val("oor_count", 64'(nvld - n0), 64'd3);

    // Randomized traffic with occasional full-ignoring and stalls.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 99) < 60);
      if (ch_full[0] && $urandom_range(0, 9) != 0) v = 1'b0;
      if ($urandom_range(0, 9) == 0) a = AW'(MEM_WORDS + $urandom_range(0, 15));
      else a = AW'($urandom_range(0, MEM_WORDS - 1));
      s = ($urandom_range(0, 99) < 25);
      cycle(v, a, s);
    end
    idle(2 * DEPTH + L + 4);

    // Reset with requests in flight.
    cycle(1'b1, AW'(20), 1'b0);
    cycle(1'b1, AW'(21), 1'b0);
    cycle(1'b1, AW'(22), 1'b0);
    rd_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 check_zero("midrst_hold");
    @(negedge clk) rst = 1'b1;
    fifo_m.delete();
    exp_m.delete();
    m_full = 1'b0; m_ovf = 1'b0; m_edge = '0;
    @(posedge clk);
    #1;
    n0 = nvld;
    idle(10);
    check_val("post_rst_no_valid", 64'(nvld - n0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
